vga_reg_writer: RTL and testbench

Avalon-MM master (initiator) that drives the VGA ball/ship display peripheral's 8-bit write-only register map. Game logic presents a full frame of state: background colour, ship position, bullet positions and the bullet-active mask. The block then serialises that frame into byte writes at addresses 0..27, honouring waitrequest. A shadow copy of the last-written bytes lets it skip unchanged registers, so per-frame bus traffic stays small.

---
 rtl/vga_regmap_pkg.sv | 25 ++
 rtl/vga_reg_pack.sv | 39 +++
 rtl/vga_reg_writer.sv | 126 ++++++++++++
 tb/tb_vga_reg_writer.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/vga_regmap_pkg.sv
// Register map constants and FSM state type for the VGA ball/ship display writer.
package vga_regmap_pkg;

    localparam int MAX_BULLETS = 5;
    localparam int N_REGS      = 8 + 4 * MAX_BULLETS;

    localparam int BG_R          = 0;
    localparam int BG_G          = 1;
    localparam int BG_B          = 2;
    localparam int SHIP_XL       = 3;
    localparam int SHIP_XH       = 4;
    localparam int SHIP_YL       = 5;
    localparam int SHIP_YH       = 6;
    localparam int BULLET_BASE   = 7;
    localparam int BULLET_STRIDE = 4;
    localparam int BULLET_ACTIVE = 27;

    typedef enum logic [1:0] {
        IDLE,
        SCAN,
        WRITE,
        DONE
    } state_t;

endpackage

// File: rtl/vga_reg_pack.sv
// Combinational mapping of game-state fields onto the peripheral's byte register image.
module vga_reg_pack
    import vga_regmap_pkg::*;
#(
    parameter int MAX_BULLETS = vga_regmap_pkg::MAX_BULLETS
) (
    input  logic [7:0]                          bg_r,
    input  logic [7:0]                          bg_g,
    input  logic [7:0]                          bg_b,
    input  logic [10:0]                         ship_x,
    input  logic [9:0]                          ship_y,
    input  logic [11*MAX_BULLETS-1:0]           bullet_x,
    input  logic [10*MAX_BULLETS-1:0]           bullet_y,
    input  logic [MAX_BULLETS-1:0]              bullet_active,
    output logic [8*(8+4*MAX_BULLETS)-1:0]      frame_bytes
);

    localparam int LOCAL_REGS = 8 + 4 * MAX_BULLETS;

    always_comb begin
        frame_bytes = '0;
        frame_bytes[8*BG_R    +: 8] = bg_r;
        frame_bytes[8*BG_G    +: 8] = bg_g;
        frame_bytes[8*BG_B    +: 8] = bg_b;
        frame_bytes[8*SHIP_XL +: 8] = ship_x[7:0];
        frame_bytes[8*SHIP_XH +: 8] = {5'b0, ship_x[10:8]};
        frame_bytes[8*SHIP_YL +: 8] = ship_y[7:0];
        frame_bytes[8*SHIP_YH +: 8] = {6'b0, ship_y[9:8]};
        for (int i = 0; i < MAX_BULLETS; i++) begin
            frame_bytes[8*(BULLET_BASE + BULLET_STRIDE*i)     +: 8] = bullet_x[11*i +: 8];
            frame_bytes[8*(BULLET_BASE + BULLET_STRIDE*i + 1) +: 8] = {5'b0, bullet_x[11*i+8 +: 3]};
            frame_bytes[8*(BULLET_BASE + BULLET_STRIDE*i + 2) +: 8] = bullet_y[10*i +: 8];
            frame_bytes[8*(BULLET_BASE + BULLET_STRIDE*i + 3) +: 8] = {6'b0, bullet_y[10*i+8 +: 2]};
        end
        // The active mask always occupies the last register.
        frame_bytes[8*(LOCAL_REGS-1) +: 8] = 8'(bullet_active);
    end

endmodule

// File: rtl/vga_reg_writer.sv
// Avalon-MM master that serialises a snapshot of the game frame into byte register writes,
// skipping bytes that match the shadow of what the peripheral already holds.
module vga_reg_writer
    import vga_regmap_pkg::*;
#(
    parameter int MAX_BULLETS    = vga_regmap_pkg::MAX_BULLETS,
    parameter bit SKIP_UNCHANGED = 1'b1
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        start,
    input  logic                        force_all,
    input  logic [7:0]                  bg_r,
    input  logic [7:0]                  bg_g,
    input  logic [7:0]                  bg_b,
    input  logic [10:0]                 ship_x,
    input  logic [9:0]                  ship_y,
    input  logic [11*MAX_BULLETS-1:0]   bullet_x,
    input  logic [10*MAX_BULLETS-1:0]   bullet_y,
    input  logic [MAX_BULLETS-1:0]      bullet_active,
    output logic                        busy,
    output logic                        done,
    output logic [4:0]                  address,
    output logic [7:0]                  writedata,
    output logic                        write,
    output logic                        chipselect,
    input  logic                        waitrequest
);

    localparam int         REG_COUNT = 8 + 4 * MAX_BULLETS;
    localparam logic [4:0] LAST_IDX  = 5'(REG_COUNT);

    state_t                     state;
    state_t                     next_state;
    logic [4:0]                 idx;
    logic                       skip_en;
    logic                       shadow_valid;
    logic [8*REG_COUNT-1:0]     packed_frame;
    logic [8*REG_COUNT-1:0]     frame;
    logic [8*REG_COUNT-1:0]     shadow;
    logic [7:0]                 cur_frame;
    logic [7:0]                 cur_shadow;

    vga_reg_pack #(
        .MAX_BULLETS (MAX_BULLETS)
    ) u_pack (
        .bg_r          (bg_r),
        .bg_g          (bg_g),
        .bg_b          (bg_b),
        .ship_x        (ship_x),
        .ship_y        (ship_y),
        .bullet_x      (bullet_x),
        .bullet_y      (bullet_y),
        .bullet_active (bullet_active),
        .frame_bytes   (packed_frame)
    );

    assign cur_frame  = frame[{idx, 3'b000} +: 8];
    assign cur_shadow = shadow[{idx, 3'b000} +: 8];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= next_state;
    end

    always_comb begin
        next_state = state;
        busy       = (state != IDLE);
        done       = (state == DONE);
        write      = (state == WRITE);
        chipselect = (state == WRITE);
        case (state)
            IDLE:  if (start) next_state = SCAN;
            SCAN: begin
                if (idx == LAST_IDX)                       next_state = DONE;
                else if (skip_en && cur_frame == cur_shadow) next_state = SCAN;
                else                                       next_state = WRITE;
            end
            WRITE: if (!waitrequest) next_state = SCAN;
            DONE:  next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Address/data are registered on entry to WRITE so they stay stable through any stall.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            idx          <= '0;
            skip_en      <= 1'b0;
            shadow_valid <= 1'b0;
            address      <= '0;
            writedata    <= '0;
            frame        <= '0;
            shadow       <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        frame   <= packed_frame;
                        skip_en <= SKIP_UNCHANGED & shadow_valid & ~force_all;
                        idx     <= '0;
                    end
                end
                SCAN: begin
                    if (idx != LAST_IDX) begin
                        if (skip_en && cur_frame == cur_shadow) begin
                            idx <= idx + 5'd1;
                        end else begin
                            address   <= idx;
                            writedata <= cur_frame;
                        end
                    end
                end
                WRITE: begin
                    if (!waitrequest) begin
                        shadow[{idx, 3'b000} +: 8] <= cur_frame;
                        idx                        <= idx + 5'd1;
                    end
                end
                DONE: shadow_valid <= 1'b1;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_vga_reg_writer.sv
// Randomised self-checking bench for vga_reg_writer against a frame/shadow reference model.
module tb_vga_reg_writer;
    import vga_regmap_pkg::*;

    localparam int NB = MAX_BULLETS;
    localparam int NR = N_REGS;

    logic               clk = 1'b0;
    logic               reset;
    logic               start;
    logic               force_all;
    logic [7:0]         bg_r, bg_g, bg_b;
    logic [10:0]        ship_x;
    logic [9:0]         ship_y;
    logic [11*NB-1:0]   bullet_x;
    logic [10*NB-1:0]   bullet_y;
    logic [NB-1:0]      bullet_active;
    logic               busy, done, write, chipselect, waitrequest;
    logic [4:0]         address;
    logic [7:0]         writedata;

    int                 checks = 0;
    int                 failures = 0;
    logic [7:0]         model_shadow [NR];
    bit                 model_valid = 0;
    logic [7:0]         exp_frame [NR];

    vga_reg_writer dut (
        .clk           (clk),
        .reset         (reset),
        .start         (start),
        .force_all     (force_all),
        .bg_r          (bg_r),
        .bg_g          (bg_g),
        .bg_b          (bg_b),
        .ship_x        (ship_x),
        .ship_y        (ship_y),
        .bullet_x      (bullet_x),
        .bullet_y      (bullet_y),
        .bullet_active (bullet_active),
        .busy          (busy),
        .done          (done),
        .address       (address),
        .writedata     (writedata),
        .write         (write),
        .chipselect    (chipselect),
        .waitrequest   (waitrequest)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, actual, expected);
        end
    endtask

    // Register image built straight from the byte map of the peripheral.
    task automatic buildFrame();
        logic [10:0] x;
        logic [9:0]  y;
        exp_frame[0] = bg_r;
        exp_frame[1] = bg_g;
        exp_frame[2] = bg_b;
        exp_frame[3] = ship_x[7:0];
        exp_frame[4] = {5'b0, ship_x[10:8]};
        exp_frame[5] = ship_y[7:0];
        exp_frame[6] = {6'b0, ship_y[9:8]};
        for (int i = 0; i < NB; i++) begin
            x = bullet_x[11*i +: 11];
            y = bullet_y[10*i +: 10];
            exp_frame[7 + 4*i]  = x[7:0];
            exp_frame[8 + 4*i]  = {5'b0, x[10:8]};
            exp_frame[9 + 4*i]  = y[7:0];
            exp_frame[10 + 4*i] = {6'b0, y[9:8]};
        end
        exp_frame[NR-1] = 8'(bullet_active);
    endtask

    task automatic randomizeFields();
        if ($urandom_range(0, 2) == 0) bg_r = 8'($urandom);
        if ($urandom_range(0, 2) == 0) bg_g = 8'($urandom);
        if ($urandom_range(0, 2) == 0) bg_b = 8'($urandom);
        if ($urandom_range(0, 2) == 0) ship_x = 11'($urandom);
        if ($urandom_range(0, 2) == 0) ship_y = 10'($urandom);
        for (int i = 0; i < NB; i++) begin
            if ($urandom_range(0, 3) == 0) bullet_x[11*i +: 11] = 11'($urandom);
            if ($urandom_range(0, 3) == 0) bullet_y[10*i +: 10] = 10'($urandom);
        end
        if ($urandom_range(0, 2) == 0) bullet_active = NB'($urandom);
    endtask

    task automatic applyStimulus(input bit f_all, input int stall_addr, input int stall_len,
                                 input int poke_cycle, input bit poke_done, input bit mutate_after,
                                 input string tag);
        int          exp_addr[$];
        logic [7:0]  exp_data[$];
        int          n_writes, stalls_left, stalls_applied, done_cycle, w;
        bit          skip, seen_done, stalled;
        logic [4:0]  held_a;
        logic [7:0]  held_d;
        buildFrame();
        skip = model_valid && !f_all;
        for (int k = 0; k < NR; k++) begin
            if (!skip || exp_frame[k] !== model_shadow[k]) begin
                exp_addr.push_back(k);
                exp_data.push_back(exp_frame[k]);
            end
        end
        start = 1'b1;
        force_all = f_all;
        waitrequest = 1'b0;
        n_writes = 0; stalls_left = stall_len; stalls_applied = 0;
        seen_done = 0; stalled = 0; done_cycle = -1;
        held_a = '0; held_d = '0;
        for (int c = 1; c <= 300 && !seen_done; c++) begin
            @(negedge clk);
            start = 1'b0;
            force_all = 1'b0;
            if (c == 1 && mutate_after) randomizeFields();
            if (c == poke_cycle) start = 1'b1;
            checkOutput({tag, " busy"}, busy, 1);
            if (write) begin
                checkOutput({tag, " chipselect"}, chipselect, 1);
                if (stalled) begin
                    checkOutput({tag, " stall addr"}, address, held_a);
                    checkOutput({tag, " stall data"}, writedata, held_d);
                end
                if (int'(address) == stall_addr && stalls_left > 0) begin
                    waitrequest = 1'b1;
                    stalls_left--;
                    stalls_applied++;
                    stalled = 1;
                    held_a = address;
                    held_d = writedata;
                end else begin
                    waitrequest = 1'b0;
                    stalled = 0;
                    if (n_writes < exp_addr.size()) begin
                        checkOutput({tag, " addr"}, address, exp_addr[n_writes]);
                        checkOutput({tag, " data"}, writedata, exp_data[n_writes]);
                    end else begin
                        checkOutput({tag, " extra write"}, n_writes + 1, exp_addr.size());
                    end
                    n_writes++;
                end
            end else begin
                waitrequest = 1'b0;
            end
            if (done) begin
                seen_done = 1;
                done_cycle = c;
                if (poke_done) start = 1'b1;
            end
        end
        w = exp_addr.size();
        checkOutput({tag, " done cycle"}, done_cycle, 2*w + (NR - w) + 2 + stalls_applied);
        checkOutput({tag, " write count"}, n_writes, w);
        for (int k = 0; k < w; k++) model_shadow[exp_addr[k]] = exp_data[k];
        model_valid = 1;
        @(negedge clk);
        start = 1'b0;
        waitrequest = 1'b0;
        checkOutput({tag, " idle after done"}, {busy, done}, 2'b00);
    endtask

    // Starts a forced frame and pulls reset while a write is on the bus.
    task automatic abortFrame();
        start = 1'b1;
        force_all = 1'b1;
        waitrequest = 1'b0;
        for (int c = 1; c <= 6; c++) begin
            @(negedge clk);
            start = 1'b0;
            force_all = 1'b0;
        end
        checkOutput("abort write before reset", write, 1);
        #2 reset = 1'b1;
        #1;
        checkOutput("abort write", write, 0);
        checkOutput("abort chipselect", chipselect, 0);
        checkOutput("abort busy/done", {busy, done}, 2'b00);
        checkOutput("abort addr/data", {address, writedata}, 13'h0);
        @(negedge clk);
        reset = 1'b0;
        model_valid = 0;
        @(negedge clk);
    endtask

    initial begin
        reset = 1'b1;
        start = 1'b0;
        force_all = 1'b0;
        waitrequest = 1'b0;
        bg_r = 8'h00; bg_g = 8'h00; bg_b = 8'h20;
        ship_x = 11'd200; ship_y = 10'd240;
        bullet_x = '0; bullet_y = '0; bullet_active = '0;
        #3;
        checkOutput("reset busy/done", {busy, done}, 2'b00);
        checkOutput("reset write/cs", {write, chipselect}, 2'b00);
        checkOutput("reset addr/data", {address, writedata}, 13'h0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        applyStimulus(0, -1, 0, 10, 0, 0, "first");
        applyStimulus(0, -1, 0, 0, 1, 0, "repeat");
        applyStimulus(1, -1, 0, 0, 0, 0, "forced");

        ship_x = 11'h5A3;
        bullet_active = 5'b10101;
        applyStimulus(0, -1, 0, 0, 0, 0, "three");

        ship_x = 11'h2A3;
        applyStimulus(0, 4, 3, 0, 0, 0, "stall");

        abortFrame();
        applyStimulus(0, -1, 0, 0, 0, 0, "after reset");

        for (int r = 0; r < 12; r++) begin
            randomizeFields();
            applyStimulus($urandom_range(0, 3) == 0, $urandom_range(0, NR-1), $urandom_range(0, 3),
                          $urandom_range(0, 40), $urandom_range(0, 1), 1'b1, "random");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
